// File: rtl/led_ctrl_pkg.sv
// ============================================================================
// Module      : led_ctrl_pkg
// Description : Shared types and helpers for the LED pattern controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_SL = 2'b00,
        MODE_SR = 2'b01,
        MODE_PP = 2'b10,
        MODE_FL = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Terminal count for speed k: 2**(nb_counter-10-k)-1
    function automatic int unsigned speed_limit(input logic [1:0] k, input int nb_counter);
        return (32'd1 << (nb_counter - 10 - int'(k))) - 32'd1;
    endfunction

    // Seed bit idx of the pattern loaded on entry to a mode
    function automatic logic seed_bit(input mode_e mode, input int idx);
        if (mode == MODE_FL) begin
            return (idx % 2) == 0;
        end
        return idx == 0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running prescaler producing a speed-selectable shift tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import led_ctrl_pkg::*;
#(
    parameter int NB_COUNTER = 16
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [1:0] i_speed,
    output logic       o_tick
);

    logic [NB_COUNTER-1:0] count_q;
    logic [NB_COUNTER-1:0] count_d;
    logic [NB_COUNTER-1:0] w_limit;
    logic                  w_tick;

    // >= rather than == so a speed change below the current count fires at once
    always_comb begin
        w_limit = NB_COUNTER'(speed_limit(i_speed, NB_COUNTER));
        w_tick  = i_enable && (count_q >= w_limit);
        count_d = count_q;
        if (i_enable) begin
            count_d = w_tick ? '0 : count_q + NB_COUNTER'(1);
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_tick = w_tick;

endmodule

`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
// ============================================================================
// Module      : led_pattern_ctrl
// Description : LED pattern scheduler: mode FSM, button sync and pattern register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int NB_LEDS    = 4,
    parameter int NB_COUNTER = 16
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [1:0]         i_speed,
    input  logic               i_color,
    input  logic               i_mode_btn,
    output logic [NB_LEDS-1:0] o_led,
    output logic [NB_LEDS-1:0] o_led_b,
    output logic [NB_LEDS-1:0] o_led_g,
    output logic [1:0]         o_mode,
    output logic               o_tick
);

    logic w_tick;

    tick_prescaler #(
        .NB_COUNTER (NB_COUNTER)
    ) u_prescaler (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_speed  (i_speed),
        .o_tick   (w_tick)
    );

    logic btn_meta_q;
    logic btn_sync_q;
    logic btn_prev_q;
    logic w_req;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            btn_meta_q <= i_mode_btn;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    assign w_req = btn_sync_q & ~btn_prev_q;

    mode_e              mode_q, mode_d, w_next_mode;
    dir_e               dir_q, dir_d;
    logic               pending_q, pending_d;
    logic [NB_LEDS-1:0] led_q, led_d, w_seed;

    always_comb begin
        w_next_mode = mode_e'(mode_q + 2'd1);
        for (int i = 0; i < NB_LEDS; i++) begin
            w_seed[i] = seed_bit(w_next_mode, i);
        end
    end

    always_comb begin
        mode_d    = mode_q;
        dir_d     = dir_q;
        led_d     = led_q;
        pending_d = pending_q;

        // A request arriving while one is already pending is dropped
        if (w_tick && pending_q) begin
            pending_d = 1'b0;
        end else if (w_req) begin
            pending_d = 1'b1;
        end

        if (w_tick) begin
            if (pending_q) begin
                mode_d = w_next_mode;
                led_d  = w_seed;
                dir_d  = DIR_LEFT;
            end else begin
                unique case (mode_q)
                    MODE_SL: led_d = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
                    MODE_SR: led_d = {led_q[0], led_q[NB_LEDS-1:1]};
                    MODE_PP: begin
                        if (dir_q == DIR_LEFT && led_q[NB_LEDS-1]) begin
                            dir_d = DIR_RIGHT;
                            led_d = led_q >> 1;
                        end else if (dir_q == DIR_RIGHT && led_q[0]) begin
                            dir_d = DIR_LEFT;
                            led_d = led_q << 1;
                        end else if (dir_q == DIR_LEFT) begin
                            led_d = led_q << 1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                    MODE_FL: led_d = ~led_q;
                    default: led_d = led_q;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            mode_q    <= MODE_SL;
            dir_q     <= DIR_LEFT;
            pending_q <= 1'b0;
            led_q     <= NB_LEDS'(1);
        end else begin
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            led_q     <= led_d;
        end
    end

    assign o_led   = led_q;
    assign o_led_b = i_color ? '0 : led_q;
    assign o_led_g = i_color ? led_q : '0;
    assign o_mode  = mode_q;
    assign o_tick  = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
// ============================================================================
// Module      : tb_led_pattern_ctrl
// Description : Directed self-checking bench for led_pattern_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_ctrl;

    logic       clock;
    logic       i_reset;
    logic       i_enable;
    logic [1:0] i_speed;
    logic       i_color;
    logic       i_mode_btn;
    logic [3:0] o_led;
    logic [3:0] o_led_b;
    logic [3:0] o_led_g;
    logic [1:0] o_mode;
    logic       o_tick;

    int checks;
    int failures;

    led_pattern_ctrl #(
        .NB_LEDS    (4),
        .NB_COUNTER (16)
    ) dut (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_speed    (i_speed),
        .i_color    (i_color),
        .i_mode_btn (i_mode_btn),
        .o_led      (o_led),
        .o_led_b    (o_led_b),
        .o_led_g    (o_led_g),
        .o_mode     (o_mode),
        .o_tick     (o_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Waits for a tick, then steps past the edge that consumes it
    task automatic wait_tick();
        int n;
        n = 0;
        while (o_tick !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (o_tick !== 1'b1) begin
            failures++;
            $display("FAIL wait_tick: o_tick=%b required 1 within 200 cycles", o_tick);
        end
        @(negedge clock);
    endtask

    task automatic press_btn(input int cycles);
        i_mode_btn = 1'b1;
        repeat (cycles) @(negedge clock);
        i_mode_btn = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_led;
        i_reset    = 1'b0;
        i_enable   = 1'b1;
        i_speed    = 2'b11;
        i_color    = 1'b0;
        i_mode_btn = 1'b0;
        repeat (3) @(negedge clock);
        checks += 5;
        if (o_led !== 4'b0001) begin failures++; $display("FAIL reset_led: got %b required 0001", o_led); end
        if (o_mode !== 2'b00) begin failures++; $display("FAIL reset_mode: got %b required 00", o_mode); end
        if (o_tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b required 0", o_tick); end
        if (o_led_b !== 4'b0001) begin failures++; $display("FAIL reset_led_b: got %b required 0001", o_led_b); end
        if (o_led_g !== 4'b0000) begin failures++; $display("FAIL reset_led_g: got %b required 0000", o_led_g); end
        i_reset = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            exp_led = 4'b0001 << ((k / 8) % 4);
            checks += 2;
            if (o_tick !== ((k % 8) == 7)) begin
                failures++;
                $display("FAIL sl_tick k=%0d: got %b required %b", k, o_tick, ((k % 8) == 7));
            end
            if (o_led !== exp_led) begin
                failures++;
                $display("FAIL sl_led k=%0d: got %b required %b", k, o_led, exp_led);
            end
            if (k < 32) @(negedge clock);
        end
    endtask

    task automatic test_speed_enable();
        i_speed = 2'b00;
        for (int j = 0; j <= 127; j++) begin
            checks++;
            if (o_tick !== (j == 63 || j == 127)) begin
                failures++;
                $display("FAIL slow_tick j=%0d: got %b required %b", j, o_tick, (j == 63 || j == 127));
            end
            if (j < 127) @(negedge clock);
        end
        checks++;
        if (o_led !== 4'b0010) begin failures++; $display("FAIL slow_led: got %b required 0010", o_led); end
        repeat (41) @(negedge clock);
        i_speed = 2'b11;
        #1;
        checks++;
        if (o_tick !== 1'b1) begin failures++; $display("FAIL speed_switch_tick: got %b required 1", o_tick); end
        for (int m = 1; m <= 16; m++) begin
            @(negedge clock);
            checks++;
            if (o_tick !== ((m % 8) == 0)) begin
                failures++;
                $display("FAIL fast_tick m=%0d: got %b required %b", m, o_tick, ((m % 8) == 0));
            end
        end
        checks++;
        if (o_led !== 4'b0001) begin failures++; $display("FAIL fast_led: got %b required 0001", o_led); end
        i_enable = 1'b0;
        #1;
        checks++;
        if (o_tick !== 1'b0) begin failures++; $display("FAIL disable_tick: got %b required 0", o_tick); end
        for (int d = 0; d < 100; d++) begin
            @(negedge clock);
            checks += 2;
            if (o_tick !== 1'b0) begin failures++; $display("FAIL frozen_tick d=%0d: got %b required 0", d, o_tick); end
            if (o_led !== 4'b0001) begin failures++; $display("FAIL frozen_led d=%0d: got %b required 0001", d, o_led); end
        end
        i_enable = 1'b1;
        #1;
        checks++;
        if (o_tick !== 1'b1) begin failures++; $display("FAIL reenable_tick: got %b required 1", o_tick); end
        @(negedge clock);
        checks++;
        if (o_led !== 4'b0010) begin failures++; $display("FAIL reenable_led: got %b required 0010", o_led); end
    endtask

    task automatic test_mode_seq();
        repeat (2) @(negedge clock);
        press_btn(3);
        @(negedge clock);
        checks++;
        if (o_mode !== 2'b00) begin failures++; $display("FAIL mode_before_tick: got %b required 00", o_mode); end
        wait_tick();
        checks += 2;
        if (o_mode !== 2'b01) begin failures++; $display("FAIL mode_sr: got %b required 01", o_mode); end
        if (o_led !== 4'b0001) begin failures++; $display("FAIL sr_seed: got %b required 0001", o_led); end
        wait_tick();
        checks++;
        if (o_led !== 4'b1000) begin failures++; $display("FAIL sr_step1: got %b required 1000", o_led); end
        wait_tick();
        checks++;
        if (o_led !== 4'b0100) begin failures++; $display("FAIL sr_step2: got %b required 0100", o_led); end
        press_btn(2);
        repeat (2) @(negedge clock);
        press_btn(2);
        wait_tick();
        checks += 2;
        if (o_mode !== 2'b10) begin failures++; $display("FAIL double_press_mode: got %b required 10", o_mode); end
        if (o_led !== 4'b0001) begin failures++; $display("FAIL pp_seed: got %b required 0001", o_led); end
    endtask

    task automatic test_ping_pong();
        logic [3:0] pp_exp [8];
        pp_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
        for (int t = 0; t < 8; t++) begin
            wait_tick();
            checks += 2;
            if (o_led !== pp_exp[t]) begin
                failures++;
                $display("FAIL pp_led t=%0d: got %b required %b", t, o_led, pp_exp[t]);
            end
            if (o_mode !== 2'b10) begin
                failures++;
                $display("FAIL pp_mode t=%0d: got %b required 10", t, o_mode);
            end
        end
    endtask

    task automatic test_flash_color();
        press_btn(3);
        wait_tick();
        checks += 2;
        if (o_mode !== 2'b11) begin failures++; $display("FAIL fl_mode: got %b required 11", o_mode); end
        if (o_led !== 4'b0101) begin failures++; $display("FAIL fl_seed: got %b required 0101", o_led); end
        wait_tick();
        checks++;
        if (o_led !== 4'b1010) begin failures++; $display("FAIL fl_step1: got %b required 1010", o_led); end
        wait_tick();
        checks++;
        if (o_led !== 4'b0101) begin failures++; $display("FAIL fl_step2: got %b required 0101", o_led); end
        i_color = 1'b1;
        #1;
        checks += 2;
        if (o_led_g !== 4'b0101) begin failures++; $display("FAIL green_bank: got %b required 0101", o_led_g); end
        if (o_led_b !== 4'b0000) begin failures++; $display("FAIL blue_off: got %b required 0000", o_led_b); end
        i_color = 1'b0;
        #1;
        checks += 2;
        if (o_led_b !== 4'b0101) begin failures++; $display("FAIL blue_bank: got %b required 0101", o_led_b); end
        if (o_led_g !== 4'b0000) begin failures++; $display("FAIL green_off: got %b required 0000", o_led_g); end
    endtask

    task automatic test_async_reset();
        press_btn(3);
        wait_tick();
        checks += 2;
        if (o_mode !== 2'b00) begin failures++; $display("FAIL wrap_mode: got %b required 00", o_mode); end
        if (o_led !== 4'b0001) begin failures++; $display("FAIL wrap_led: got %b required 0001", o_led); end
        press_btn(3);
        wait_tick();
        press_btn(3);
        wait_tick();
        wait_tick();
        wait_tick();
        checks += 2;
        if (o_mode !== 2'b10) begin failures++; $display("FAIL pre_reset_mode: got %b required 10", o_mode); end
        if (o_led !== 4'b0100) begin failures++; $display("FAIL pre_reset_led: got %b required 0100", o_led); end
        press_btn(3);
        repeat (2) @(negedge clock);
        #2;
        i_reset = 1'b0;
        #1;
        checks += 3;
        if (o_led !== 4'b0001) begin failures++; $display("FAIL async_led: got %b required 0001", o_led); end
        if (o_mode !== 2'b00) begin failures++; $display("FAIL async_mode: got %b required 00", o_mode); end
        if (o_tick !== 1'b0) begin failures++; $display("FAIL async_tick: got %b required 0", o_tick); end
        repeat (2) @(negedge clock);
        i_reset = 1'b1;
        wait_tick();
        checks += 2;
        if (o_mode !== 2'b00) begin failures++; $display("FAIL pending_cleared: got %b required 00", o_mode); end
        if (o_led !== 4'b0010) begin failures++; $display("FAIL post_reset_led: got %b required 0010", o_led); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_speed_enable();
        test_mode_seq();
        test_ping_pong();
        test_flash_color();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
